// File: rtl/gmii_tx_mac.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS, then inter-frame gap (1G bytes or 10/100 nibbles).
// Each byte is registered on the byte_start edge that produces it; tx_ready is high only on DATA byte slots with tx_valid.
module gmii_tx_mac #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic       tx_clk,
  input  logic       tx_reset,
  input  logic       gmii_txc_en,
  input  logic       speed_10_100,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_PAD  = 3'd4;
  localparam logic [2:0] S_FCS  = 3'd5;
  localparam logic [2:0] S_IFG  = 3'd6;

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);

  logic [2:0]  state, state_n;
  logic        mode_nib, mode_n;
  logic        nib_phase, phase_n;
  logic [7:0]  cnt, cnt_n;
  logic [10:0] pay_cnt, pay_n, pay_inc;
  logic [31:0] crc, crc_n;
  logic [3:0]  hi_nib;
  logic        fcs_tail, tail_n;
  logic        done_n, und_n;
  logic [7:0]  e_byte;
  logic        e_en, e_er;
  logic        byte_start;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign byte_start = gmii_txc_en & (~mode_nib | ~nib_phase);
  assign tx_ready   = (state == S_DATA) & byte_start & tx_valid;
  assign tx_busy    = (state != S_IDLE);
  assign pay_inc    = (pay_cnt == 11'h7FF) ? pay_cnt : pay_cnt + 11'd1;

  // Everything below describes the byte emitted and the state taken on the next byte_start.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pay_n   = pay_cnt;
    crc_n   = crc;
    mode_n  = mode_nib;
    tail_n  = fcs_tail;
    done_n  = 1'b0;
    und_n   = 1'b0;
    e_byte  = 8'h00;
    e_en    = 1'b0;
    e_er    = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          mode_n  = speed_10_100;
          e_byte  = 8'h55;
          e_en    = 1'b1;
          cnt_n   = 8'd1;
          state_n = (PREAMBLE_LEN > 1) ? S_PRE : S_SFD;
        end
      end
      S_PRE: begin
        e_byte = 8'h55;
        e_en   = 1'b1;
        cnt_n  = cnt + 8'd1;
        if (cnt == PRE_LAST) state_n = S_SFD;
      end
      S_SFD: begin
        e_byte  = 8'hD5;
        e_en    = 1'b1;
        crc_n   = 32'hFFFFFFFF;
        pay_n   = 11'd0;
        state_n = S_DATA;
      end
      S_DATA: begin
        e_en  = 1'b1;
        cnt_n = 8'd0;
        if (tx_valid) begin
          e_byte = tx_data;
          crc_n  = crc_byte(crc, tx_data);
          pay_n  = pay_inc;
          if (tx_last) state_n = (pay_inc < MIN_CNT) ? S_PAD : S_FCS;
        end else begin
          e_er    = 1'b1;
          und_n   = 1'b1;
          tail_n  = 1'b0;
          state_n = S_IFG;
        end
      end
      S_PAD: begin
        e_en  = 1'b1;
        crc_n = crc_byte(crc, 8'h00);
        pay_n = pay_inc;
        cnt_n = 8'd0;
        if (pay_inc >= MIN_CNT) state_n = S_FCS;
      end
      S_FCS: begin
        e_byte = ~crc[{cnt[1:0], 3'b000} +: 8];
        e_en   = 1'b1;
        cnt_n  = cnt + 8'd1;
        if (cnt == 8'd3) begin
          cnt_n   = 8'd0;
          tail_n  = 1'b1;
          state_n = S_IFG;
        end
      end
      S_IFG: begin
        // The first IFG slot edge is the one that ends the final FCS byte.
        done_n = fcs_tail;
        tail_n = 1'b0;
        cnt_n  = cnt + 8'd1;
        if (cnt == IFG_LAST) begin
          cnt_n   = 8'd0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    phase_n = mode_n & ~((state == S_IDLE) & ~tx_valid);
  end

  always_ff @(posedge tx_clk or posedge tx_reset) begin
    if (tx_reset) begin
      state      <= S_IDLE;
      mode_nib   <= 1'b0;
      nib_phase  <= 1'b0;
      cnt        <= 8'd0;
      pay_cnt    <= 11'd0;
      crc        <= 32'hFFFFFFFF;
      hi_nib     <= 4'h0;
      fcs_tail   <= 1'b0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      if (byte_start) begin
        state      <= state_n;
        cnt        <= cnt_n;
        pay_cnt    <= pay_n;
        crc        <= crc_n;
        mode_nib   <= mode_n;
        fcs_tail   <= tail_n;
        nib_phase  <= phase_n;
        hi_nib     <= e_byte[7:4];
        gmii_txd   <= mode_n ? {4'h0, e_byte[3:0]} : e_byte;
        gmii_tx_en <= e_en;
        gmii_tx_er <= e_er;
        frame_done <= done_n;
        underrun   <= und_n;
      end else if (gmii_txc_en) begin
        gmii_txd  <= {4'h0, hi_nib};
        nib_phase <= 1'b0;
      end
    end
  end

endmodule
